alu_multicycle: RTL and testbench

- Parametrised WIDTH-bit ALU.
- Combines a ripple/behavioural single-cycle datapath with a bit-serial shift-add unsigned multiplier.
- Replaces the per-bit ALU slice in the datapath. A valid/ready handshake lets the multi-cycle MULU op stall the issuing stage.
- All results are registered: flags, result and completion pulse appear together.

---
 rtl/alu_pkg.sv | 19 +
 rtl/alu_mul_serial.sv | 49 ++++
 rtl/alu_multicycle.sv | 138 +++++++++++++
 tb/tb_alu_multicycle.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared op-code and FSM encodings for the multi-cycle ALU.
package alu_pkg;

  localparam int CTRL_W = 4;

  localparam logic [CTRL_W-1:0] OP_AND  = 4'b0000;
  localparam logic [CTRL_W-1:0] OP_OR   = 4'b0001;
  localparam logic [CTRL_W-1:0] OP_ADD  = 4'b0010;
  localparam logic [CTRL_W-1:0] OP_SUB  = 4'b0110;
  localparam logic [CTRL_W-1:0] OP_SLT  = 4'b0111;
  localparam logic [CTRL_W-1:0] OP_NOR  = 4'b1100;
  localparam logic [CTRL_W-1:0] OP_MULU = 4'b1000;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } alu_state_e;

endpackage

// File: rtl/alu_mul_serial.sv
// Bit-serial shift-add unsigned multiplier, one multiplier bit per cycle.
module alu_mul_serial #(
  parameter int WIDTH = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               done_o,
  output logic [2*WIDTH-1:0] prod_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [CNT_W-1:0]   cnt_q;

  // Product after this cycle's step; valid as the final product when done_o is high.
  always_comb begin
    acc_d = acc_q;
    if (mplier_q[0]) acc_d = acc_q + mcand_q;
  end

  assign done_o = (cnt_q == CNT_W'(1));
  assign prod_o = acc_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else if (start_i) begin
      acc_q    <= '0;
      mcand_q  <= {{WIDTH{1'b0}}, a_i};
      mplier_q <= b_i;
      cnt_q    <= CNT_W'(WIDTH);
    end else if (cnt_q != '0) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// WIDTH-bit ALU: single-cycle logic/arith ops plus a multi-cycle MULU behind valid/ready.
// Handshake: a request is taken on a rising edge where valid_i && ready_o; valid_o pulses once per completed request.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [WIDTH-1:0]  src1_i,
  input  logic [WIDTH-1:0]  src2_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic [WIDTH-1:0]  result_o,
  output logic [WIDTH-1:0]  result_hi_o,
  output logic              zero_o,
  output logic              cout_o,
  output logic              overflow_o,
  output logic              illegal_o,
  output logic              valid_o
);

  alu_state_e       state_q;
  logic             ready_q, valid_q, zero_q, cout_q, ovf_q, illegal_q;
  logic [WIDTH-1:0] result_q, result_hi_q;

  logic [WIDTH:0]   sum_w, diff_w;
  logic             ovf_add, ovf_sub;
  logic [WIDTH-1:0] alu_res_d;
  logic             alu_cout_d, alu_ovf_d, alu_illegal_d;
  logic             accept, mul_start, mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  assign accept    = valid_i && ready_q;
  assign mul_start = accept && (ctrl_i == OP_MULU);

  assign sum_w   = {1'b0, src1_i} + {1'b0, src2_i};
  assign diff_w  = {1'b0, src1_i} + {1'b0, ~src2_i} + {{WIDTH{1'b0}}, 1'b1};
  assign ovf_add = (src1_i[WIDTH-1] == src2_i[WIDTH-1]) && (sum_w[WIDTH-1] != src1_i[WIDTH-1]);
  assign ovf_sub = (src1_i[WIDTH-1] != src2_i[WIDTH-1]) && (diff_w[WIDTH-1] != src1_i[WIDTH-1]);

  always_comb begin
    alu_res_d     = '0;
    alu_cout_d    = 1'b0;
    alu_ovf_d     = 1'b0;
    alu_illegal_d = 1'b0;
    case (ctrl_i)
      OP_AND: alu_res_d = src1_i & src2_i;
      OP_OR:  alu_res_d = src1_i | src2_i;
      OP_NOR: alu_res_d = ~(src1_i | src2_i);
      OP_ADD: begin
        alu_res_d  = sum_w[WIDTH-1:0];
        alu_cout_d = sum_w[WIDTH];
        alu_ovf_d  = ovf_add;
      end
      OP_SUB: begin
        alu_res_d  = diff_w[WIDTH-1:0];
        alu_cout_d = diff_w[WIDTH];
        alu_ovf_d  = ovf_sub;
      end
      // Sign of the difference corrected by overflow gives a true signed compare.
      OP_SLT:  alu_res_d = {{(WIDTH-1){1'b0}}, diff_w[WIDTH-1] ^ ovf_sub};
      OP_MULU: alu_res_d = '0;
      default: alu_illegal_d = 1'b1;
    endcase
  end

  alu_mul_serial #(.WIDTH(WIDTH)) u_mul (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (mul_start),
    .a_i     (src1_i),
    .b_i     (src2_i),
    .done_o  (mul_done),
    .prod_o  (mul_prod)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      ready_q     <= 1'b1;
      valid_q     <= 1'b0;
      result_q    <= '0;
      result_hi_q <= '0;
      zero_q      <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (mul_start) begin
            state_q <= ST_BUSY;
            ready_q <= 1'b0;
          end else if (accept) begin
            result_q    <= alu_res_d;
            result_hi_q <= '0;
            zero_q      <= (alu_res_d == '0);
            cout_q      <= alu_cout_d;
            ovf_q       <= alu_ovf_d;
            illegal_q   <= alu_illegal_d;
            valid_q     <= 1'b1;
          end
        end
        ST_BUSY: begin
          if (mul_done) begin
            result_q    <= mul_prod[WIDTH-1:0];
            result_hi_q <= mul_prod[2*WIDTH-1:WIDTH];
            zero_q      <= (mul_prod[WIDTH-1:0] == '0);
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            illegal_q   <= 1'b0;
            valid_q     <= 1'b1;
            state_q     <= ST_IDLE;
            ready_q     <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign ready_o     = ready_q;
  assign valid_o     = valid_q;
  assign result_o    = result_q;
  assign result_hi_o = result_hi_q;
  assign zero_o      = zero_q;
  assign cout_o      = cout_q;
  assign overflow_o  = ovf_q;
  assign illegal_o   = illegal_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle with hand-computed expected values.
module tb_alu_multicycle;

  localparam int WIDTH  = 32;
  localparam int CTRL_W = 4;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              valid_i = 1'b0;
  logic              ready_o;
  logic [WIDTH-1:0]  src1_i = '0;
  logic [WIDTH-1:0]  src2_i = '0;
  logic [CTRL_W-1:0] ctrl_i = '0;
  logic [WIDTH-1:0]  result_o, result_hi_o;
  logic              zero_o, cout_o, overflow_o, illegal_o, valid_o;

  int n_checks = 0;
  int n_fail   = 0;

  alu_multicycle #(.WIDTH(WIDTH), .CTRL_W(CTRL_W)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .src1_i      (src1_i),
    .src2_i      (src2_i),
    .ctrl_i      (ctrl_i),
    .result_o    (result_o),
    .result_hi_o (result_hi_o),
    .zero_o      (zero_o),
    .cout_o      (cout_o),
    .overflow_o  (overflow_o),
    .illegal_o   (illegal_o),
    .valid_o     (valid_o)
  );

  // Clock / reset
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one request; returns #1 after the accepting edge.
  task automatic issue(input logic [CTRL_W-1:0] op, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b);
    ctrl_i  = op;
    src1_i  = a;
    src2_i  = b;
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
  endtask

  // Checks result, hi, zero, cout, overflow, illegal, valid together.
  task automatic chk_out(input string tag, input logic [WIDTH-1:0] res, input logic [WIDTH-1:0] hi,
                         input logic z, input logic c, input logic v, input logic il, input logic vo);
    chk({tag, ".result"},   64'(result_o),    64'(res));
    chk({tag, ".hi"},       64'(result_hi_o), 64'(hi));
    chk({tag, ".zero"},     64'(zero_o),      64'(z));
    chk({tag, ".cout"},     64'(cout_o),      64'(c));
    chk({tag, ".overflow"}, 64'(overflow_o),  64'(v));
    chk({tag, ".illegal"},  64'(illegal_o),   64'(il));
    chk({tag, ".valid"},    64'(valid_o),     64'(vo));
  endtask

  initial begin
    rst_i = 1'b1;
    repeat (2) tick();
    chk_out("reset", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset.ready", 64'(ready_o), 64'd1);
    rst_i = 1'b0;
    tick();

    // ADD
    issue(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001);
    chk_out("add_ovf", 32'h8000_0000, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    chk("add_ovf.pulse_end", 64'(valid_o), 64'd0);
    chk("add_ovf.hold", 64'(result_o), 64'h8000_0000);
    issue(4'b0010, 32'hFFFF_FFFF, 32'h0000_0001);
    chk_out("add_carry", 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);

    // SUB / SLT
    issue(4'b0110, 32'd5, 32'd7);
    chk_out("sub_neg", 32'hFFFF_FFFE, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    issue(4'b0110, 32'd7, 32'd5);
    chk_out("sub_pos", 32'h0000_0002, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    issue(4'b0111, 32'h8000_0000, 32'h0000_0001);
    chk_out("slt_neg", 32'h1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    issue(4'b0111, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
    chk_out("slt_ovf", 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    // MULU, with valid_i held high (as an ADD) throughout BUSY
    ctrl_i = 4'b1000; src1_i = 32'hFFFF_FFFF; src2_i = 32'hFFFF_FFFF; valid_i = 1'b1;
    tick();
    ctrl_i = 4'b0010; src1_i = 32'd1; src2_i = 32'd1;
    chk("mulu.accept_ready", 64'(ready_o), 64'd0);
    chk("mulu.accept_valid", 64'(valid_o), 64'd0);
    for (int k = 1; k < WIDTH; k++) begin
      tick();
      chk($sformatf("mulu.busy_ready[%0d]", k), 64'(ready_o), 64'd0);
      chk($sformatf("mulu.busy_valid[%0d]", k), 64'(valid_o), 64'd0);
    end
    tick();
    valid_i = 1'b0;
    chk_out("mulu_done", 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("mulu_done.ready", 64'(ready_o), 64'd1);
    tick();
    chk("mulu_after.valid", 64'(valid_o), 64'd0);
    chk("mulu_after.result", 64'(result_o), 64'h1);

    // Back-to-back logic ops
    ctrl_i = 4'b0000; src1_i = 32'hF0F0_F0F0; src2_i = 32'h0FF0_0FF0; valid_i = 1'b1;
    tick();
    chk_out("b2b_and", 32'h00F0_00F0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    ctrl_i = 4'b0001;
    tick();
    chk_out("b2b_or", 32'hFFF0_FFF0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    ctrl_i = 4'b1100;
    tick();
    valid_i = 1'b0;
    chk_out("b2b_nor", 32'h000F_000F, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset 10 cycles into a MULU
    issue(4'b1000, 32'd3, 32'd5);
    repeat (9) tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk_out("mid_rst", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("mid_rst.ready", 64'(ready_o), 64'd1);
    for (int k = 0; k < 30; k++) begin
      tick();
      chk($sformatf("mid_rst.no_valid[%0d]", k), 64'(valid_o), 64'd0);
    end
    issue(4'b0010, 32'd2, 32'd3);
    chk_out("post_rst_add", 32'd5, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Illegal op, then a legal op clears the flag
    issue(4'b1111, 32'h1234_5678, 32'h9ABC_DEF0);
    chk_out("illegal", 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    issue(4'b0001, 32'd1, 32'd2);
    chk_out("illegal_clear", 32'd3, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset and request on the same edge: request dropped
    rst_i = 1'b1;
    issue(4'b0010, 32'd1, 32'd1);
    rst_i = 1'b0;
    chk_out("rst_wins", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("rst_wins.later_valid", 64'(valid_o), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
